// File: rtl/mem_access_ctrl_if.sv
// Request/response and data-memory bus bundle for mem_access_ctrl.
// slave = controller view, master = core/memory (testbench) view.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        done;
    logic        exc;
    logic [63:0] load_data;
    logic [63:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, done, exc, load_data, mem_addr, mem_rd, mem_wr, mem_wdata
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, done, exc, load_data, mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer for a 64-bit doubleword memory with fixed read latency:
// lane select + extension on loads, read-modify-write for sub-doubleword stores.
module mem_access_ctrl #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    mem_access_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, RD, WAIT, WR, DONE} state_e;

    state_e      state_q, state_d;
    logic        store_q, store_d;
    logic [2:0]  f3_q, f3_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [63:0] load_data_q, load_data_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
    logic        exc_q, exc_d;
    logic [3:0]  cnt_q, cnt_d;

    // request decode (combinational on the incoming request)
    logic req_illegal, req_misal, req_exc;
    always_comb begin
        req_illegal = bus.req_store ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);
        case (bus.req_funct3[1:0])
            2'd1:    req_misal = bus.req_addr[0];
            2'd2:    req_misal = |bus.req_addr[1:0];
            2'd3:    req_misal = |bus.req_addr[2:0];
            default: req_misal = 1'b0;
        endcase
        req_exc = req_illegal | req_misal;
    end

    // lane extraction/extension and store merge on the registered request
    logic [5:0]  shamt;
    logic [63:0] lane, ext, wsh, merged;
    logic [7:0]  byte_en, byte_en_sh;
    logic        sgn;
    always_comb begin
        shamt = {addr_q[2:0], 3'b000};
        lane  = bus.mem_rdata >> shamt;
        wsh   = wdata_q << shamt;
        sgn   = ~f3_q[2];
        case (f3_q[1:0])
            2'd0:    begin ext = {{56{sgn & lane[7]}},  lane[7:0]};  byte_en = 8'h01; end
            2'd1:    begin ext = {{48{sgn & lane[15]}}, lane[15:0]}; byte_en = 8'h03; end
            2'd2:    begin ext = {{32{sgn & lane[31]}}, lane[31:0]}; byte_en = 8'h0F; end
            default: begin ext = lane;                               byte_en = 8'hFF; end
        endcase
        byte_en_sh = byte_en << addr_q[2:0];
        for (int i = 0; i < 8; i++)
            merged[8*i +: 8] = byte_en_sh[i] ? wsh[8*i +: 8] : bus.mem_rdata[8*i +: 8];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            store_q     <= 1'b0;
            f3_q        <= 3'd0;
            addr_q      <= 64'd0;
            wdata_q     <= 64'd0;
            load_data_q <= 64'd0;
            mem_wdata_q <= 64'd0;
            exc_q       <= 1'b0;
            cnt_q       <= 4'd0;
        end else begin
            state_q     <= state_d;
            store_q     <= store_d;
            f3_q        <= f3_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            mem_wdata_q <= mem_wdata_d;
            exc_q       <= exc_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                if (req_exc)                                          state_d = DONE;
                else if (bus.req_store && bus.req_funct3[1:0] == 2'd3) state_d = WR;
                else                                                  state_d = RD;
            end
            RD:   state_d = WAIT;
            WAIT: if (cnt_q == 4'd0) state_d = store_q ? WR : DONE;
            WR:   state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        store_d     = store_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;
        mem_wdata_d = mem_wdata_q;
        exc_d       = exc_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                store_d     = bus.req_store;
                f3_d        = bus.req_funct3;
                addr_d      = bus.req_addr;
                wdata_d     = bus.req_wdata;
                exc_d       = req_exc;
                mem_wdata_d = bus.req_wdata;
                if (req_exc) load_data_d = 64'd0;
            end
            RD:   cnt_d = 4'(MEM_LAT - 1);
            WAIT: begin
                if (cnt_q != 4'd0)  cnt_d       = cnt_q - 4'd1;
                else if (store_q)   mem_wdata_d = merged;
                else                load_data_d = ext;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.mem_rd    = (state_q == RD);
        bus.mem_wr    = (state_q == WR);
        bus.done      = (state_q == DONE);
        bus.exc       = (state_q == DONE) & exc_q;
        bus.mem_addr  = (state_q == IDLE) ? 64'd0 : {addr_q[63:3], 3'b000};
        bus.load_data = load_data_q;
        bus.mem_wdata = mem_wdata_q;
    end
endmodule
